// File: rtl/tl_pkg.sv
// Shared types, lamp encodings and default durations for the traffic-light phase scheduler.
package tl_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b100;

    localparam int         DEF_CLK_HZ   = 50_000_000;
    localparam logic [6:0] DEF_MAX_S    = 7'd99;
    localparam logic [6:0] DEF_GREEN_S  = 7'd25;
    localparam logic [6:0] DEF_YELLOW_S = 7'd5;
    localparam logic [6:0] DEF_RED_S    = 7'd30;

    typedef enum logic {
        ST_CONFIG,
        ST_RUN
    } tl_state_e;

    typedef enum logic [1:0] {
        PH_GREEN,
        PH_YELLOW,
        PH_RED
    } tl_phase_e;

    function automatic tl_phase_e next_phase(input tl_phase_e p);
        case (p)
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_GREEN;
        endcase
    endfunction

    function automatic logic [2:0] phase_light(input tl_phase_e p);
        case (p)
            PH_GREEN:  return LIGHT_GREEN;
            PH_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    // Zero would stall the countdown, so it is promoted to one second.
    function automatic logic [6:0] clamp_duration(input logic [6:0] v, input logic [6:0] max_s);
        if (v == 7'd0)
            return 7'd1;
        if (v > max_s)
            return max_s;
        return v;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and flags the last count as a tick.
module tl_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic resetTL,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!resetTL || clear)
            r_count <= '0;
        else if (en)
            r_count <= (r_count == LAST) ? '0 : r_count + CNT_W'(1);
    end

    assign tick = en && (r_count == LAST);

endmodule

// File: rtl/tl_phase_scheduler.sv
// Traffic-light phase scheduler: CONFIG mode edits per-phase durations, RUN mode cycles
// GREEN -> YELLOW -> RED with a one-second countdown.
module tl_phase_scheduler
    import tl_pkg::*;
#(
    parameter int         CLK_HZ     = DEF_CLK_HZ,
    parameter logic [6:0] MAX_SECOND = DEF_MAX_S,
    parameter logic [6:0] DEF_GREEN  = DEF_GREEN_S,
    parameter logic [6:0] DEF_YELLOW = DEF_YELLOW_S,
    parameter logic [6:0] DEF_RED    = DEF_RED_S
) (
    input  logic       CLOCK_50,
    input  logic       resetTL,
    input  logic       start,
    input  logic [2:0] cfg_light,
    input  logic [6:0] cfg_value,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic [2:0] light_state,
    output logic [6:0] countdown,
    output logic       enableIR,
    output logic       tick
);

    tl_state_e  r_state, w_state_nxt;
    tl_phase_e  r_phase, w_wr_phase;
    logic [6:0] r_countdown;
    logic [6:0] r_dur_green, r_dur_yellow, r_dur_red;
    logic [6:0] w_dur_green_nxt, w_dur_yellow_nxt, w_dur_red_nxt;
    logic [6:0] w_wr_value, w_next_dur;
    logic       r_enable_ir;
    logic       w_write, w_cfg_onehot, w_run_entry, w_run_en, w_tick;

    tl_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .resetTL  (resetTL),
        .clear    (w_run_entry),
        .en       (w_run_en),
        .tick     (w_tick)
    );

    // State register; enableIR is registered alongside so it never glitches on mode changes.
    always_ff @(posedge CLOCK_50) begin
        if (!resetTL) begin
            r_state     <= ST_CONFIG;
            r_enable_ir <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_enable_ir <= (w_state_nxt == ST_CONFIG);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CONFIG: if (start)  w_state_nxt = ST_RUN;
            ST_RUN:    if (!start) w_state_nxt = ST_CONFIG;
            default:               w_state_nxt = ST_CONFIG;
        endcase
    end

    always_comb begin
        cfg_ready   = (r_state == ST_CONFIG);
        w_run_en    = (r_state == ST_RUN);
        w_run_entry = (r_state == ST_CONFIG) && start;
        light_state = phase_light(r_phase);
        countdown   = r_countdown;
        enableIR    = r_enable_ir;
        tick        = w_tick;
    end

    // Write decode; only reachable in CONFIG because cfg_ready gates it.
    always_comb begin
        w_cfg_onehot = cfg_light inside {LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN};
        w_write      = cfg_valid && cfg_ready && w_cfg_onehot;
        w_wr_value   = clamp_duration(cfg_value, MAX_SECOND);
        case (cfg_light)
            LIGHT_GREEN:  w_wr_phase = PH_GREEN;
            LIGHT_YELLOW: w_wr_phase = PH_YELLOW;
            default:      w_wr_phase = PH_RED;
        endcase
        w_dur_green_nxt  = (w_write && w_wr_phase == PH_GREEN)  ? w_wr_value : r_dur_green;
        w_dur_yellow_nxt = (w_write && w_wr_phase == PH_YELLOW) ? w_wr_value : r_dur_yellow;
        w_dur_red_nxt    = (w_write && w_wr_phase == PH_RED)    ? w_wr_value : r_dur_red;
    end

    always_comb begin
        case (next_phase(r_phase))
            PH_GREEN:  w_next_dur = r_dur_green;
            PH_YELLOW: w_next_dur = r_dur_yellow;
            default:   w_next_dur = r_dur_red;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetTL) begin
            r_dur_green  <= DEF_GREEN;
            r_dur_yellow <= DEF_YELLOW;
            r_dur_red    <= DEF_RED;
        end else begin
            r_dur_green  <= w_dur_green_nxt;
            r_dur_yellow <= w_dur_yellow_nxt;
            r_dur_red    <= w_dur_red_nxt;
        end
    end

    // Leaving RUN takes priority over a coincident tick, so no decrement is lost or doubled.
    always_ff @(posedge CLOCK_50) begin
        if (!resetTL) begin
            r_phase     <= PH_RED;
            r_countdown <= DEF_RED;
        end else begin
            case (r_state)
                ST_CONFIG: begin
                    if (start) begin
                        r_phase     <= PH_GREEN;
                        r_countdown <= w_dur_green_nxt;
                    end else if (w_write) begin
                        r_phase     <= w_wr_phase;
                        r_countdown <= w_wr_value;
                    end
                end
                ST_RUN: begin
                    if (!start) begin
                        r_phase     <= PH_RED;
                        r_countdown <= r_dur_red;
                    end else if (w_tick) begin
                        if (r_countdown > 7'd1) begin
                            r_countdown <= r_countdown - 7'd1;
                        end else begin
                            r_phase     <= next_phase(r_phase);
                            r_countdown <= w_next_dur;
                        end
                    end
                end
                default: begin
                    r_phase     <= PH_RED;
                    r_countdown <= r_dur_red;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Randomized and directed bench for tl_phase_scheduler against an elapsed-time reference model.
module tb_tl_phase_scheduler;

    localparam int HZ = 10;

    logic       clk = 1'b0;
    logic       resetTL, start, cfg_valid;
    logic [2:0] cfg_light;
    logic [6:0] cfg_value;
    logic       cfg_ready, enableIR, tick;
    logic [2:0] light_state;
    logic [6:0] countdown;

    always #5 clk = ~clk;

    tl_phase_scheduler #(
        .CLK_HZ (HZ)
    ) dut (
        .CLOCK_50    (clk),
        .resetTL     (resetTL),
        .start       (start),
        .cfg_light   (cfg_light),
        .cfg_value   (cfg_value),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .light_state (light_state),
        .countdown   (countdown),
        .enableIR    (enableIR),
        .tick        (tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: durations indexed 0=green 1=yellow 2=red; in RUN the displayed phase is derived
    // from the number of whole seconds elapsed since RUN entry.
    bit m_run;
    int m_dur[3];
    int m_elapsed;
    int m_cfg_ph;
    int exp_light, exp_cd, exp_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int light_code(input int idx);
        case (idx)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int light_idx(input logic [2:0] l);
        case (l)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_edge();
        int idx, v;
        if (!resetTL) begin
            m_run     = 1'b0;
            m_dur     = '{25, 5, 30};
            m_cfg_ph  = 2;
            m_elapsed = 0;
        end else if (m_run) begin
            if (!start) begin
                m_run    = 1'b0;
                m_cfg_ph = 2;
            end else begin
                m_elapsed++;
            end
        end else begin
            idx = light_idx(cfg_light);
            if (cfg_valid && idx >= 0) begin
                v = int'(cfg_value);
                if (v == 0) v = 1;
                else if (v > 99) v = 99;
                m_dur[idx] = v;
                m_cfg_ph   = idx;
            end
            if (start) begin
                m_run     = 1'b1;
                m_elapsed = 0;
            end
        end
    endtask

    task automatic model_expect();
        int total, pos, p;
        if (m_run) begin
            total = m_dur[0] + m_dur[1] + m_dur[2];
            pos   = (m_elapsed / HZ) % total;
            p     = 0;
            while (pos >= m_dur[p]) begin
                pos -= m_dur[p];
                p++;
            end
            exp_light = light_code(p);
            exp_cd    = m_dur[p] - pos;
            exp_tick  = ((m_elapsed % HZ) == HZ - 1) ? 1 : 0;
        end else begin
            exp_light = light_code(m_cfg_ph);
            exp_cd    = m_dur[m_cfg_ph];
            exp_tick  = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_expect();
        check("light_state", 32'(light_state), 32'(exp_light));
        check("countdown",   32'(countdown),   32'(exp_cd));
        check("tick",        32'(tick),        32'(exp_tick));
        check("enableIR",    32'(enableIR),    32'(!m_run));
        check("cfg_ready",   32'(cfg_ready),   32'(!m_run));
    endtask

    int seen[$];
    logic [2:0] prev_light;

    initial begin
        resetTL   = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_light = 3'b001;
        cfg_value = 7'd0;
        step();
        step();
        check("rst_light", 32'(light_state), 32'd1);
        check("rst_cd",    32'(countdown),   32'd30);
        check("rst_ir",    32'(enableIR),    32'd1);
        check("rst_tick",  32'(tick),        32'd0);

        // Default cycle: 240 cycles to reach 1, yellow at 250, full period 600.
        resetTL = 1'b1;
        step();
        start = 1'b1;
        step();
        check("entry_cd", 32'(countdown), 32'd25);
        prev_light = light_state;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (light_state !== prev_light) seen.push_back(int'(light_state));
            prev_light = light_state;
            if (i == 240) check("cd_at_240", 32'(countdown), 32'd1);
            if (i == 250) begin
                check("light_at_250", 32'(light_state), 32'd2);
                check("cd_at_250",    32'(countdown),   32'd5);
            end
        end
        check("order_count", 32'(seen.size()), 32'd3);
        check("order_0", 32'(seen[0]), 32'd2);
        check("order_1", 32'(seen[1]), 32'd1);
        check("order_2", 32'(seen[2]), 32'd4);
        check("period_cd", 32'(countdown), 32'd25);

        // start=0 on a tick while green shows 3.
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        repeat (229) step();
        check("pre_stop_tick", 32'(tick),      32'd1);
        check("pre_stop_cd",   32'(countdown), 32'd3);
        start = 1'b0;
        step();
        check("stop_light", 32'(light_state), 32'd1);
        check("stop_cd",    32'(countdown),   32'd30);
        check("stop_ir",    32'(enableIR),    32'd1);

        // Writes attempted during RUN must be ignored.
        start = 1'b1;
        step();
        cfg_valid = 1'b1;
        cfg_light = 3'b100;
        cfg_value = 7'd50;
        for (int i = 0; i < 30; i++) begin
            step();
            check("run_ready", 32'(cfg_ready), 32'd0);
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        step();
        start = 1'b1;
        step();
        check("reentry_cd",    32'(countdown),   32'd25);
        check("reentry_light", 32'(light_state), 32'd4);

        // Config write arithmetic and one-hot filtering.
        start = 1'b0;
        step();
        cfg_valid = 1'b1;
        cfg_light = 3'b100;
        cfg_value = 7'd0;
        step();
        check("wr_zero", 32'(countdown), 32'd1);
        check("wr_zero_light", 32'(light_state), 32'd4);
        cfg_value = 7'd120;
        step();
        check("wr_clamp", 32'(countdown), 32'd99);
        cfg_value = 7'd7;
        step();
        check("wr_plain", 32'(countdown), 32'd7);
        cfg_light = 3'b011;
        cfg_value = 7'd50;
        step();
        check("wr_bad_cd",    32'(countdown),   32'd7);
        check("wr_bad_light", 32'(light_state), 32'd4);
        cfg_light = 3'b000;
        step();
        check("wr_zero_sel", 32'(countdown), 32'd7);
        cfg_valid = 1'b0;
        start     = 1'b1;
        step();
        check("new_green", 32'(countdown), 32'd7);

        // Reset mid-yellow with a coincident tick and an attempted write.
        resetTL = 1'b0;
        step();
        resetTL = 1'b1;
        step();
        repeat (259) step();
        check("pre_rst_tick",  32'(tick),        32'd1);
        check("pre_rst_light", 32'(light_state), 32'd2);
        resetTL   = 1'b0;
        cfg_valid = 1'b1;
        cfg_light = 3'b100;
        cfg_value = 7'd60;
        step();
        check("mid_rst_light", 32'(light_state), 32'd1);
        check("mid_rst_cd",    32'(countdown),   32'd30);
        check("mid_rst_ir",    32'(enableIR),    32'd1);
        check("mid_rst_tick",  32'(tick),        32'd0);
        resetTL   = 1'b1;
        cfg_valid = 1'b0;
        step();
        check("post_rst_run", 32'(enableIR),  32'd0);
        check("post_rst_cd",  32'(countdown), 32'd25);

        // Randomized traffic: mode toggles, writes, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) start = ~start;
            resetTL   = ($urandom_range(0, 799) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_light = 3'($urandom_range(0, 7));
            cfg_value = 7'($urandom_range(0, 127));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_phase_scheduler.md
TL_PHASE_SCHEDULER -- requirements
Module: tl_phase_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000; CLOCK_50 cycles per 1 s tick.
REQ-002 Parameter MAX_SECOND, default 7'd99; maximum phase duration in seconds.
REQ-003 Parameters DEF_GREEN, DEF_YELLOW, DEF_RED, defaults 7'd25, 7'd5, 7'd30; per-phase durations loaded at reset.
REQ-004 CLOCK_50  in  1  system clock; the only clock.
REQ-005 resetTL  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  1 = run the cycle; 0 = configuration mode.
REQ-007 cfg_light  in  3  one-hot phase being edited: 3'b001 red, 3'b010 yellow, 3'b100 green.
REQ-008 cfg_value  in  7  new duration in seconds for cfg_light.
REQ-009 cfg_valid  in  1  write request; qualifies cfg_light and cfg_value.
REQ-010 cfg_ready  out  1  high when a write is accepted this cycle.
REQ-011 light_state  out  3  driven lamp, one-hot, same encoding as cfg_light.
REQ-012 countdown  out  7  seconds remaining in the current phase (RUN), or stored duration of the displayed phase (CONFIG).
REQ-013 enableIR  out  1  high in CONFIG; gates the IR number-entry path.
REQ-014 tick  out  1  one-cycle pulse every CLK_HZ cycles while in RUN.

Function
REQ-015 The FSM SHALL have two states, CONFIG and RUN, plus a phase register holding GREEN, YELLOW or RED.
REQ-016 CONFIG->RUN SHALL occur on the first clock with start=1. On that edge: phase=GREEN, countdown=dur_green, prescaler=0.
REQ-017 RUN->CONFIG SHALL occur on the first clock with start=0. On that edge: light_state=RED, countdown=dur_red.
REQ-018 If start=0 and a tick occur on the same clock, the start=0 transition SHALL win; no decrement occurs.
REQ-019 In RUN, the prescaler SHALL count 0..CLK_HZ-1 and wrap. tick SHALL be asserted for the one cycle in which the count equals CLK_HZ-1. The first tick SHALL come CLK_HZ cycles after RUN entry.
REQ-020 On a tick with countdown>1, countdown SHALL decrement by 1 on the following edge.
REQ-021 On a tick with countdown==1, the phase SHALL advance GREEN->YELLOW->RED->GREEN. countdown SHALL load the new phase's duration on the same edge. countdown never shows 0 in RUN.
REQ-022 cfg_ready SHALL equal (state==CONFIG) combinationally.
REQ-023 A write SHALL occur when cfg_valid && cfg_ready and cfg_light is one-hot. Non-one-hot cfg_light SHALL be ignored with no state change.
REQ-024 Write arithmetic: cfg_value==0 SHALL store 1; cfg_value>MAX_SECOND SHALL store MAX_SECOND; otherwise cfg_value SHALL be stored unchanged.
REQ-025 In CONFIG, after a valid write, light_state SHALL equal the last written cfg_light. countdown SHALL show that phase's stored duration, updated on the same edge as the write.
REQ-026 cfg_valid in RUN SHALL be ignored. Durations SHALL change only in CONFIG, so a running phase is never altered mid-count.
REQ-027 enableIR SHALL equal (state==CONFIG) and be registered together with the state.
REQ-028 light_state SHALL always be exactly one-hot; no other value is ever driven.

Reset
REQ-029 resetTL=0 at a rising edge SHALL set, on that edge:
- state=CONFIG, phase=RED, light_state=3'b001;
- countdown=DEF_RED; dur_* = DEF_*;
- prescaler=0, tick=0, enableIR=1.
REQ-030 Reset asserted mid-RUN SHALL override all other inputs, including a coincident tick or write.
REQ-031 If start=1 after reset release, RUN SHALL be entered on the next edge.

Structure
REQ-032 Package tl_pkg SHALL hold:
- light encodings LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN;
- the FSM state enum;
- the phase enum and the next_phase function;
- default durations.
REQ-033 The prescaler SHALL be a sub-module tl_tick_gen (ports CLOCK_50, resetTL, clear, en, tick). clear SHALL be asserted on RUN entry; en SHALL be asserted in RUN.
REQ-034 All state SHALL be in one clock domain; no derived clocks.

Verification (CLK_HZ=10 in simulation)
REQ-035 Reset, then start=1 -> GREEN, countdown=25. Countdown SHALL reach 1 after 240 cycles. At cycle 250, light_state=010 and countdown=5.
REQ-036 Full cycle with defaults -> order GREEN, YELLOW, RED, GREEN. Period = (25+5+30)*10 = 600 cycles.
REQ-037 In CONFIG, write cfg_light=100 with cfg_value=0, then 120, then 7 -> stored 1, 99, 7. cfg_light=011 -> no change.
REQ-038 start=0 on a tick cycle during GREEN countdown=3 -> next edge: CONFIG, light_state=001, countdown=30, enableIR=1.
REQ-039 cfg_valid during RUN -> cfg_ready=0 and durations unchanged. After RUN->CONFIG->RUN, GREEN SHALL reload the original 25.
REQ-040 resetTL=0 mid-YELLOW with a coincident tick -> all REQ-029 values on that edge; tick low afterwards.
